// File: rtl/clk_period_meter_if.sv
// Measurement bus for clk_period_meter.
//   sig_in     : signal under measurement (sampled as data, never used as a clock)
//   enable     : measurement enable
//   period     : clk_in cycles between the last two detected rising edges
//   high_time  : clk_in cycles the signal was high within that period
//   meas_valid : one-cycle pulse when period/high_time update
//   timeout    : sticky loss-of-toggle flag
//   edge_cnt   : wrapping count of detected rising edges
//   busy       : meter is armed or measuring
// slave = meter side, master = stimulus/observer side.
interface clk_period_meter_if #(
  parameter int CW = 16
);
  logic          sig_in;
  logic          enable;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          timeout;
  logic [7:0]    edge_cnt;
  logic          busy;

  modport slave (
    input  sig_in, enable,
    output period, high_time, meas_valid, timeout, edge_cnt, busy
  );

  modport master (
    output sig_in, enable,
    input  period, high_time, meas_valid, timeout, edge_cnt, busy
  );
endinterface

// File: rtl/clk_period_meter.sv
// Period / high-time meter for a slow signal sampled in the clk_in domain.
// The signal goes through a 3-flop chain; a rising edge is seen as
// s2 & ~s3. Because the detect latency is the same for every edge, the
// distance between two detected rises is the exact period in clk_in cycles.
//   clk_in : sole clock
//   reset  : asynchronous, active-low
//   bus    : clk_period_meter_if.slave (sig_in/enable in, results out)
// TIMEOUT_CYC must satisfy 2 <= TIMEOUT_CYC < 2**CW.
module clk_period_meter #(
  parameter int CW          = 16,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                   clk_in,
  input  logic                   reset,
  clk_period_meter_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYC);

  state_t        state, state_nxt;
  logic [2:0]    sync;              // sync[0]=s1, sync[1]=s2, sync[2]=s3
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] hcnt, hcnt_nxt;
  logic [CW-1:0] period_q, period_nxt;
  logic [CW-1:0] high_q, high_nxt;
  logic          mv_q, mv_nxt;
  logic          to_q, to_nxt;
  logic [7:0]    ecnt_q, ecnt_nxt;
  logic          rise, lvl;

  // Synchronizer keeps running regardless of enable.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) sync <= '0;
    else        sync <= {sync[1:0], bus.sig_in};
  end

  assign lvl  = sync[1];
  assign rise = sync[1] & ~sync[2];

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      hcnt     <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      to_q     <= 1'b0;
      ecnt_q   <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hcnt     <= hcnt_nxt;
      period_q <= period_nxt;
      high_q   <= high_nxt;
      mv_q     <= mv_nxt;
      to_q     <= to_nxt;
      ecnt_q   <= ecnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hcnt_nxt   = hcnt;
    period_nxt = period_q;
    high_nxt   = high_q;
    mv_nxt     = 1'b0;
    to_nxt     = to_q;
    ecnt_nxt   = ecnt_q;
    if (!bus.enable) begin
      // Results and edge count survive a disable; everything else restarts.
      state_nxt = IDLE;
      cnt_nxt   = '0;
      hcnt_nxt  = '0;
      to_nxt    = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_nxt   = '0;
          hcnt_nxt  = '0;
          state_nxt = ARM;
        end
        ARM: begin
          if (rise) begin
            // First edge only opens a period; nothing to report yet.
            cnt_nxt   = CW'(1);
            hcnt_nxt  = CW'(1);
            ecnt_nxt  = ecnt_q + 8'd1;
            state_nxt = MEASURE;
          end else if (cnt == TO_CNT) begin
            to_nxt  = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle is a legal period of TIMEOUT_CYC.
          if (rise) begin
            period_nxt = cnt;
            high_nxt   = hcnt;
            mv_nxt     = 1'b1;
            cnt_nxt    = CW'(1);
            hcnt_nxt   = CW'(1);
            ecnt_nxt   = ecnt_q + 8'd1;
          end else if (cnt == TO_CNT) begin
            to_nxt    = 1'b1;
            cnt_nxt   = '0;
            hcnt_nxt  = '0;
            state_nxt = ARM;
          end else begin
            cnt_nxt  = cnt + CW'(1);
            hcnt_nxt = hcnt + {{(CW-1){1'b0}}, lvl};
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = mv_q;
  assign bus.timeout    = to_q;
  assign bus.edge_cnt   = ecnt_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter. The reference model works on timestamps:
// it remembers every sampled sig_in value, the clock index of the last
// detected rise and of the arm point, and derives period/high_time by
// differencing timestamps and summing the sampled level history.
module tb_clk_period_meter;
  localparam int CW = 16;
  localparam int T  = 20;

  logic clk_in = 1'b0;
  logic reset;

  clk_period_meter_if #(.CW(CW)) bus();

  clk_period_meter #(.CW(CW), .TIMEOUT_CYC(T)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int ec;                 // posedges since reset release (1-based)
  bit xs [0:32767];       // sig_in as sampled at each posedge
  int ms;                 // 0 idle, 1 arm, 2 measure
  int arm_t, last_rise;
  int m_per, m_ht, m_ecnt;
  bit m_mv, m_to;

  // Level seen by the edge detector at posedge j: sample from two edges back.
  function automatic bit lvlat(input int j);
    if (j - 2 >= 1) return xs[j-2];
    return 1'b0;
  endfunction

  task automatic model_reset();
    ec = 0; ms = 0; arm_t = 0; last_rise = 0;
    m_per = 0; m_ht = 0; m_ecnt = 0; m_mv = 0; m_to = 0;
  endtask

  task automatic model_step(input bit s, input bit en);
    bit rise;
    int sum;
    ec++;
    xs[ec] = s;
    rise = lvlat(ec) && !lvlat(ec - 1);
    m_mv = 0;
    if (!en) begin
      ms = 0; m_to = 0;
    end else begin
      case (ms)
        0: begin ms = 1; arm_t = ec; end
        1: begin
          if (rise) begin last_rise = ec; m_ecnt++; ms = 2; end
          else if (ec - arm_t - 1 == T) begin m_to = 1; arm_t = ec; end
        end
        default: begin
          if (rise) begin
            sum = 0;
            for (int j = last_rise; j < ec; j++) sum += int'(lvlat(j));
            m_per = ec - last_rise;
            m_ht  = sum;
            m_mv  = 1;
            last_rise = ec;
            m_ecnt++;
          end else if (ec - last_rise == T) begin
            m_to = 1; ms = 1; arm_t = ec;
          end
        end
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".period"},     32'(bus.period),     32'(m_per));
    check({tag, ".high_time"},  32'(bus.high_time),  32'(m_ht));
    check({tag, ".meas_valid"}, 32'(bus.meas_valid), 32'(m_mv));
    check({tag, ".timeout"},    32'(bus.timeout),    32'(m_to));
    check({tag, ".edge_cnt"},   32'(bus.edge_cnt),   32'(m_ecnt % 256));
    check({tag, ".busy"},       32'(bus.busy),       32'(ms != 0));
  endtask

  // One clk_in cycle: drive after negedge, model the posedge, check at negedge.
  task automatic tick(input bit s, input bit en, input string tag);
    bus.sig_in = s;
    bus.enable = en;
    @(posedge clk_in);
    model_step(s, en);
    @(negedge clk_in);
    check_all(tag);
  endtask

  task automatic seg(input bit s, input int n, input bit en, input string tag);
    for (int k = 0; k < n; k++) tick(s, en, tag);
  endtask

  initial begin
    bit t;
    int guard;
    int p_hold, h_hold;

    bus.sig_in = 1'b0;
    bus.enable = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check_all("reset");
    reset = 1'b1;

    // Divide-by-2 input
    for (int i = 0; i < 40; i++) tick(i[0], 1'b1, "div2");
    check("div2_period_const", 32'(bus.period), 32'd2);
    check("div2_high_const",   32'(bus.high_time), 32'd1);

    // High 3 / low 5
    for (int r = 0; r < 6; r++) begin
      seg(1'b1, 3, 1'b1, "h3l5");
      seg(1'b0, 5, 1'b1, "h3l5");
    end
    check("h3l5_period_const", 32'(bus.period), 32'd8);
    check("h3l5_high_const",   32'(bus.high_time), 32'd3);

    // Stuck low: timeout in ARM, sticky through later measurements
    tick(1'b0, 1'b0, "dis1");
    seg(1'b0, 70, 1'b1, "stuck");
    check("stuck_timeout_const", 32'(bus.timeout), 32'd1);
    for (int r = 0; r < 4; r++) begin
      seg(1'b1, 3, 1'b1, "resume");
      seg(1'b0, 5, 1'b1, "resume");
    end
    check("resume_timeout_sticky", 32'(bus.timeout), 32'd1);

    // Period exactly TIMEOUT_CYC is a measurement; TIMEOUT_CYC+1 times out
    tick(1'b0, 1'b0, "dis2");
    for (int r = 0; r < 5; r++) begin
      seg(1'b1, 10, 1'b1, "p_eq_to");
      seg(1'b0, 10, 1'b1, "p_eq_to");
    end
    check("p_eq_to_period_const", 32'(bus.period), 32'(T));
    check("p_eq_to_no_timeout",   32'(bus.timeout), 32'd0);
    for (int r = 0; r < 3; r++) begin
      seg(1'b1, 10, 1'b1, "p_gt_to");
      seg(1'b0, 11, 1'b1, "p_gt_to");
    end

    // Async reset in MEASURE, between clock edges
    for (int r = 0; r < 3; r++) begin
      seg(1'b1, 3, 1'b1, "pre_rst");
      seg(1'b0, 5, 1'b1, "pre_rst");
    end
    bus.sig_in = 1'b1;
    @(posedge clk_in);
    model_step(1'b1, 1'b1);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all("async_rst");
    @(negedge clk_in);
    reset = 1'b1;

    // 300 rises -> edge_cnt wraps to 44
    t = 1'b1;
    guard = 0;
    while (m_ecnt < 300 && guard < 2000) begin
      t = !t;
      tick(t, 1'b1, "wrap");
      guard++;
    end
    check("wrap_edge_cnt_44", 32'(bus.edge_cnt), 32'd44);

    // Disable mid-period
    for (int r = 0; r < 2; r++) begin
      seg(1'b1, 3, 1'b1, "mid");
      seg(1'b0, 5, 1'b1, "mid");
    end
    seg(1'b1, 2, 1'b1, "mid");
    p_hold = m_per;
    h_hold = m_ht;
    tick(1'b1, 1'b0, "dis_mid");
    check("dis_mid_period_hold", 32'(bus.period), 32'(p_hold));
    check("dis_mid_high_hold",   32'(bus.high_time), 32'(h_hold));
    check("dis_mid_busy",        32'(bus.busy), 32'd0);
    check("dis_mid_mv",          32'(bus.meas_valid), 32'd0);

    // Randomized durations with occasional enable drops
    for (int r = 0; r < 40; r++) begin
      seg(1'b1, int'($urandom_range(1, 25)), 1'b1, "rand");
      seg(1'b0, int'($urandom_range(1, 25)), 1'b1, "rand");
      if ($urandom_range(0, 9) == 0) tick(1'b0, 1'b0, "rand_dis");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
